// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants and helpers for the Viterbi decoder front end.
//   SYM_W_DEF / NUM_SYM_DEF : default symbol width and symbols per word
//   MSB_FIRST / LSB_FIRST   : bit-order encodings for serialisers
//   cnt_w(n)                : width of a counter that must hold 0..n
package viterbi_pkg;
    localparam int SYM_W_DEF   = 2;
    localparam int NUM_SYM_DEF = 8;
    localparam bit MSB_FIRST   = 1'b0;
    localparam bit LSB_FIRST   = 1'b1;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/piso_hold_buf.sv
// piso_hold_buf: one-entry {data, len, last} holding register with full flag.
//   clk, rst_n    : clock, async active-low reset (clears entry and flag)
//   wr_i          : load data_i/len_i/last_i and mark full
//   rd_i          : release the entry (contents are left in place)
//   full_o        : entry occupied
//   data_o/len_o/last_o : stored entry
module piso_hold_buf
    import viterbi_pkg::*;
#(
    parameter int DATA_W = SYM_W_DEF * NUM_SYM_DEF,
    parameter int CNT_W  = cnt_w(NUM_SYM_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_i,
    input  logic              rd_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              last_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  len_o,
    output logic              last_o
);
    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  len_q;
    logic              last_q;

    // a write always wins so a same-cycle release and refill keeps the entry
    assign full_d = wr_i | (full_q & ~rd_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            len_q  <= '0;
            last_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wr_i) begin
                data_q <= data_i;
                len_q  <= len_i;
                last_q <= last_i;
            end
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign len_o  = len_q;
    assign last_o = last_q;
endmodule

// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out converter with hold buffer and backpressure.
//   clk, rst_n                         : clock, async active-low reset
//   in_valid_i/in_ready_o              : input word handshake
//   in_data_i, in_len_i, in_last_i     : word, symbol count (0 or >NUM_SYM = full), frame-last tag
//   sym_o/sym_valid_o/sym_ready_i      : output symbol stream
//   sym_last_o                         : final symbol of a word tagged last
//   busy_o                             : shift stage or hold buffer occupied
module piso_stream
    import viterbi_pkg::*;
#(
    parameter int SYM_W     = SYM_W_DEF,
    parameter int NUM_SYM   = NUM_SYM_DEF,
    parameter bit LSB_FIRST = MSB_FIRST,
    localparam int DATA_W   = SYM_W * NUM_SYM,
    localparam int CNT_W    = cnt_w(NUM_SYM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CNT_W-1:0]  in_len_i,
    input  logic              in_last_i,
    output logic [SYM_W-1:0]  sym_o,
    output logic              sym_valid_o,
    input  logic              sym_ready_i,
    output logic              sym_last_o,
    output logic              busy_o
);
    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(NUM_SYM);

    logic [DATA_W-1:0] data_q, data_d, shifted;
    logic [CNT_W-1:0]  cnt_q, cnt_d, len_n;
    logic              last_q, last_d;
    logic              hold_full, hold_last, hold_wr, hold_rd;
    logic [DATA_W-1:0] hold_data;
    logic [CNT_W-1:0]  hold_len;
    logic              shift_full, consume, final_sym, accept, to_shift;

    assign len_n      = (in_len_i == '0 || in_len_i > FULL_LEN) ? FULL_LEN : in_len_i;
    assign shift_full = cnt_q != '0;
    assign consume    = shift_full & sym_ready_i;
    assign final_sym  = consume & (cnt_q == CNT_W'(1));
    assign accept     = in_valid_i & in_ready_o;
    // straight into the shift stage only if it would otherwise sit empty next cycle
    assign to_shift   = accept & (~shift_full | (final_sym & ~hold_full));
    assign hold_wr    = accept & ~to_shift;
    assign hold_rd    = final_sym & hold_full;
    assign shifted    = LSB_FIRST ? data_q >> SYM_W : data_q << SYM_W;

    piso_hold_buf #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_i   (hold_wr),
        .rd_i   (hold_rd),
        .data_i (in_data_i),
        .len_i  (len_n),
        .last_i (in_last_i),
        .full_o (hold_full),
        .data_o (hold_data),
        .len_o  (hold_len),
        .last_o (hold_last)
    );

    // an emptied stage is cleared so sym_o idles at 0
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (hold_rd) begin
            data_d = hold_data;
            cnt_d  = hold_len;
            last_d = hold_last;
        end else if (to_shift) begin
            data_d = in_data_i;
            cnt_d  = len_n;
            last_d = in_last_i;
        end else if (final_sym) begin
            data_d = '0;
            cnt_d  = '0;
            last_d = 1'b0;
        end else if (consume) begin
            data_d = shifted;
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign sym_o       = LSB_FIRST ? data_q[SYM_W-1:0] : data_q[DATA_W-1 -: SYM_W];
    assign sym_valid_o = shift_full;
    assign sym_last_o  = last_q & (cnt_q == CNT_W'(1));
    assign in_ready_o  = ~hold_full;
    assign busy_o      = shift_full | hold_full;
endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: directed checks of piso_stream in MSB-first and LSB-first builds.
module tb_piso_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [3:0]  in_len = '0;
    logic        in_last = 1'b0;
    logic        sym_ready = 1'b1;
    logic        rdy_m, val_m, last_m, busy_m;
    logic        rdy_l, val_l, last_l, busy_l;
    logic [1:0]  sym_m, sym_l;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    piso_stream #(.SYM_W(2), .NUM_SYM(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_m),
        .in_data_i(in_data), .in_len_i(in_len), .in_last_i(in_last),
        .sym_o(sym_m), .sym_valid_o(val_m), .sym_ready_i(sym_ready),
        .sym_last_o(last_m), .busy_o(busy_m)
    );

    piso_stream #(.SYM_W(2), .NUM_SYM(8), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_l),
        .in_data_i(in_data), .in_len_i(in_len), .in_last_i(in_last),
        .sym_o(sym_l), .sym_valid_o(val_l), .sym_ready_i(sym_ready),
        .sym_last_o(last_l), .busy_o(busy_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // em/el hold the expected symbol sequences packed first-emitted in the top bits
    task automatic run_word(input logic [15:0] d, input logic [3:0] len, input logic last,
                            input int n, input logic [15:0] em, input logic [15:0] el);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = len;
        in_last  = last;
        check("accept_ready", rdy_m, 1'b1);
        step;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("valid_m", val_m, 1'b1);
            check("sym_m", sym_m, em[15-2*i -: 2]);
            check("sym_l", sym_l, el[15-2*i -: 2]);
            check("last_m", last_m, last && i == n - 1);
            check("last_l", last_l, last && i == n - 1);
            step;
        end
        check("idle_valid", val_m, 1'b0);
        check("idle_busy", busy_m, 1'b0);
    endtask

    initial begin
        int idx;
        int c;
        step;
        check("rst_valid", val_m, 1'b0);
        check("rst_last", last_m, 1'b0);
        check("rst_sym", sym_m, 2'd0);
        check("rst_busy", busy_m, 1'b0);
        check("rst_ready", rdy_m, 1'b1);
        rst_n = 1'b1;
        step;

        // full word, MSB and LSB orders, untagged then tagged
        run_word(16'hB4E1, 4'd8, 1'b0, 8, 16'hB4E1, 16'h4B1E);
        run_word(16'hB4E1, 4'd8, 1'b1, 8, 16'hB4E1, 16'h4B1E);

        // back-to-back words with no bubble
        in_valid = 1'b1;
        in_data  = 16'hB4E1;
        in_len   = 4'd8;
        in_last  = 1'b0;
        step;
        in_data = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            logic [15:0] w;
            w = 16'hB4E1;
            check("b2b_valid", val_m, 1'b1);
            check("b2b_sym", sym_m, k < 8 ? w[15-2*k -: 2] : 2'd3);
            if (k == 0 || k == 8) check("b2b_ready_hi", rdy_m, 1'b1);
            if (k >= 1 && k <= 7) check("b2b_ready_lo", rdy_m, 1'b0);
            if (k == 1) in_valid = 1'b0;
            step;
        end
        check("b2b_end", val_m, 1'b0);

        // backpressure, ready pattern 1,0,0,1
        in_valid = 1'b1;
        in_data  = 16'hB4E1;
        in_len   = 4'd8;
        step;
        in_valid = 1'b0;
        idx = 0;
        c = 0;
        while (idx < 8 && c < 40) begin
            logic [15:0] w;
            w = 16'hB4E1;
            sym_ready = (c % 4 == 0) || (c % 4 == 3);
            check("bp_valid", val_m, 1'b1);
            check("bp_sym", sym_m, w[15-2*idx -: 2]);
            check("bp_busy", busy_m, 1'b1);
            if (sym_ready) idx++;
            c++;
            step;
        end
        check("bp_done", idx, 8);
        sym_ready = 1'b1;
        check("bp_idle_valid", val_m, 1'b0);
        check("bp_idle_busy", busy_m, 1'b0);

        // partial length then illegal length 0
        run_word(16'hB4E1, 4'd3, 1'b1, 3, 16'hB400, 16'h4800);
        run_word(16'hB4E1, 4'd0, 1'b0, 8, 16'hB4E1, 16'h4B1E);
        run_word(16'hB4E1, 4'd9, 1'b1, 8, 16'hB4E1, 16'h4B1E);

        // reset mid-word with hold occupied
        in_valid = 1'b1;
        in_data  = 16'hB4E1;
        in_len   = 4'd8;
        in_last  = 1'b1;
        step;
        in_data = 16'hFFFF;
        step;
        in_valid = 1'b0;
        step;
        step;
        check("mid_sym3", sym_m, 2'd0);
        check("mid_hold_full", rdy_m, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", val_m, 1'b0);
        check("mrst_busy", busy_m, 1'b0);
        check("mrst_ready", rdy_m, 1'b1);
        check("mrst_sym", sym_m, 2'd0);
        step;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step;
            check("post_valid_m", val_m, 1'b0);
            check("post_valid_l", val_l, 1'b0);
            check("post_busy", busy_m, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out converter that feeds encoded symbols into the Viterbi decoder front end.
- Accepts DATA_W-bit words on a valid/ready input handshake and emits SYM_W-bit symbols on a valid/ready output stream.
- Successor to the fixed 16-bit/2-bit, load-pulse converter. Adds:
  - width, depth and bit-order parameters;
  - downstream backpressure;
  - a one-word holding buffer for gap-free back-to-back words;
  - partial-word length;
  - frame-last propagation.

Parameters:
- SYM_W, 2, bits per output symbol (2 for rate-1/2 code).
- NUM_SYM, 8, symbols per full input word; DATA_W = SYM_W*NUM_SYM (localparam).
- LSB_FIRST, 0, 0 = emit most-significant symbol first; 1 = emit least-significant symbol first.

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- in_valid_i, input, 1, input word valid.
- in_ready_o, output, 1, block can accept a word this cycle.
- in_data_i, input, DATA_W, parallel word.
- in_len_i, input, CNT_W = $clog2(NUM_SYM+1), number of symbols to emit from this word.
- in_last_i, input, 1, word is last of frame.
- sym_o, output, SYM_W, current symbol.
- sym_valid_o, output, 1, sym_o valid.
- sym_ready_i, input, 1, downstream accepts symbol.
- sym_last_o, output, 1, final symbol of a word tagged in_last_i.
- busy_o, output, 1, shift stage or hold buffer occupied.

Behaviour:
- Reset (async assert, sync release):
  - Both stages empty; data registers cleared to 0.
  - sym_valid_o=0, sym_last_o=0, sym_o=0, busy_o=0.
  - in_ready_o=1 while in reset and afterwards, because hold is empty.
- Input handshake:
  - A word is accepted on a cycle where in_valid_i & in_ready_o.
  - in_ready_o = !hold_full. It is registered-state derived, with no combinational path from sym_ready_i.
- Length:
  - in_len_i values 1..NUM_SYM are used as given.
  - A value of 0 or greater than NUM_SYM is treated as NUM_SYM.
  - Symbols are taken from the first-emitted end. For MSB-first that is the upper symbols; for LSB-first that is the lower symbols. Unused symbols are never output.
- Routing of an accepted word:
  - It goes directly into the shift stage if, after this cycle, the shift stage would be empty. This covers two cases: the stage is already empty, or its final symbol is consumed this cycle while hold is empty.
  - Otherwise it goes into the hold buffer.
- Output:
  - sym_valid_o=1 whenever the shift stage holds a word.
  - Latency: word accepted in cycle N into an empty block → first symbol valid in cycle N+1.
  - Symbol advances on sym_valid_o & sym_ready_i: shift by SYM_W (left if MSB-first, right if LSB-first) and decrement the remaining count.
  - While sym_valid_o & !sym_ready_i, sym_o, sym_last_o and sym_valid_o hold stable.
- Word boundary:
  - When the final symbol is consumed and hold is full, the hold word moves to the shift stage the same cycle. The next symbol is valid in the next cycle, giving sustained throughput of 1 symbol/cycle with no bubble.
  - Hold frees that cycle, so in_ready_o=1 the next cycle.
  - A new input on the same cycle then goes to hold, not lost.
- sym_last_o = remaining_count==1 & word_last flag; it is 0 for all other symbols.
- Simultaneous events: accept, final-symbol consume and hold→shift transfer in one cycle must all complete. There is no word loss, duplication or reordering.
- Reset mid-operation discards both stages immediately; there is no partial output after release.
- busy_o = shift_full | hold_full.

Decomposition:
- Shared package viterbi_pkg holds:
  - SYM_W default constant (2) and NUM_SYM default (8);
  - a clog2-based CNT_W helper function;
  - the bit-order encodings MSB_FIRST=0 and LSB_FIRST=1.
- One natural sub-module: piso_hold_buf. It is a one-entry register {data, len, last} with full flag, write/read strobes and async reset, instantiated for the hold stage.
- Shift stage, routing and counters live in piso_stream.

Test Plan:
- MSB-first, word 0xB4E1, len 8, sym_ready_i=1 → symbols 2,3,1,0,3,2,0,1 on 8 consecutive cycles starting cycle after accept; sym_last_o=0 throughout (in_last_i=0).
- LSB_FIRST=1, word 0xB4E1, len 8, in_last_i=1 → symbols 1,0,2,3,0,1,3,2; sym_last_o=1 only on final symbol 2.
- Back-to-back: words 0xB4E1 then 0xFFFF presented continuously, ready=1 → 16 contiguous valid cycles (2,3,1,0,3,2,0,1,3×8); in_ready_o=0 while hold full, no gap between words.
- Backpressure: sym_ready_i toggling 1,0,0,1,… on 0xB4E1 → each symbol held stable while ready=0; exact sequence preserved; busy_o=1 until last accepted.
- Partial/illegal length: 0xB4E1, len 3, last=1 → 2,3,1 with sym_last_o on 1; then len 0 → full 8 symbols emitted.
- Reset mid-word: assert rst_n=0 after 3rd symbol with hold full → next cycle sym_valid_o=0, busy_o=0, in_ready_o=1; after release no stale symbols appear.
